// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } sa_state_e;

   localparam int SA_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Full-adder cell: two half-adder stages with an OR merging their carries.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   logic h1_s;
   logic h1_c;
   logic h2_c;

   assign h1_s = x ^ y;
   assign h1_c = x & y;
   assign s    = h1_s ^ ci;
   assign h2_c = h1_s & ci;
   assign co   = h1_c | h2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder, one full-adder cell reused over WIDTH cycles.
// Define SERIAL_ADDER_SIGNED_OVF_EN to add the signed-overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SERIAL_ADDER_SIGNED_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   sa_state_e        state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             carry_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;
   logic             fa_s;
   logic             fa_co;

   fa_cell u_fa (
      .x  (a_q[0]),
      .y  (b_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   assign sum_d = {fa_s, sum_q[WIDTH-1:1]};
   assign cnt_d = cnt_q + CW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  carry_q    <= cin;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               sum_q   <= sum_d;
               carry_q <= fa_co;
               cnt_q   <= cnt_d;
               if (cnt_q == CNT_LAST) begin
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               // in_ready stays low here, so in_valid cannot be taken this edge
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SERIAL_ADDER_SIGNED_OVF_EN
   logic ovf_q;

   // On the MSB step carry_q is the carry into the MSB, fa_co the carry out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state_q == S_SHIFT && cnt_q == CNT_LAST) begin
         ovf_q <= carry_q ^ fa_co;
      end
   end

   assign ovf = ovf_q;
`endif

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign cout      = carry_q;

endmodule
